// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller (master) drives the control strobes and selects and consumes
// opcode, zero and mem_ready.
interface multicycle_control_if;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  aluop;
  logic        reg_write;
  logic        illegal_instr;
  logic [31:0] instret;
  logic [3:0]  state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           aluop, reg_write, illegal_instr, instret, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
           aluop, reg_write, illegal_instr, instret, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Main FSM for a multicycle RV32I subset (load, store, R-type, I-type ALU,
// jal, beq). Controls are Moore-decoded from state. The exceptions are the
// FETCH handshake strobes, the beq PC write and the illegal-opcode pulse.
// A retired-instruction counter is also kept here.
module multicycle_control (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] EXECI    = 4'd8;
  localparam logic [3:0] JAL      = 4'd9;
  localparam logic [3:0] BEQ      = 4'd10;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  logic [3:0]  state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic        pc_update;
  logic        illegal;

  // Next-state logic; mem_ready is only consulted in FETCH, MEMREAD and MEMWRITE
  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    unique case (state_q)
      FETCH:    if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_JAL:            state_d = JAL;
          OP_BEQ:            state_d = BEQ;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:  if (bus.mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWRITE: if (bus.mem_ready) state_d = FETCH;
      EXECR:    state_d = ALUWB;
      EXECI:    state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // An instruction retires when a completing state hands back to FETCH;
  // the illegal-opcode path leaves DECODE and is deliberately excluded
  always_comb begin
    retire = 1'b0;
    if (state_d == FETCH) begin
      unique case (state_q)
        MEMWB, MEMWRITE, ALUWB, BEQ: retire = 1'b1;
        default:                     retire = 1'b0;
      endcase
    end
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Moore decode of the mux selects, plus gated strobes (held low during reset)
  always_comb begin
    bus.adr_src    = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.aluop      = 2'b00;
    pc_update      = 1'b0;
    bus.mem_write  = 1'b0;
    bus.reg_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    unique case (state_q)
      FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.ir_write   = bus.mem_ready;
        pc_update      = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      MEMREAD:  bus.adr_src = 1'b1;
      MEMWB: begin
        bus.result_src = 2'b01;
        bus.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src   = 1'b1;
        bus.mem_write = 1'b1;
      end
      EXECR: begin
        bus.alu_src_a = 2'b10;
        bus.aluop     = 2'b10;
      end
      EXECI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.aluop     = 2'b10;
      end
      ALUWB:    bus.reg_write = 1'b1;
      JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pc_update     = 1'b1;
      end
      BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.aluop     = 2'b01;
      end
      default: ;
    endcase
    bus.pc_write      = rst_n & (pc_update | ((state_q == BEQ) & bus.zero));
    bus.ir_write      = rst_n & bus.ir_write;
    bus.mem_write     = rst_n & bus.mem_write;
    bus.reg_write     = rst_n & bus.reg_write;
    bus.illegal_instr = rst_n & illegal;
  end

  assign bus.instret = instret_q;
  assign bus.state   = state_q;

endmodule
